// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the synchronous SPI slave.
//   SPI_MODE0..SPI_MODE3 : {CPOL, CPHA} encodings for the mode input
//   spi_state_t          : frame FSM state (IDLE / ACTIVE)
//   sample_on_rise()     : true when the sample edge is the rising sclk edge
package spi_pkg;

   localparam logic [1:0] SPI_MODE0 = 2'b00;
   localparam logic [1:0] SPI_MODE1 = 2'b01;
   localparam logic [1:0] SPI_MODE2 = 2'b10;
   localparam logic [1:0] SPI_MODE3 = 2'b11;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_state_t;

   // Data is sampled on the rising sclk edge when CPOL == CPHA, otherwise
   // on the falling edge; the opposite edge shifts.
   function automatic logic sample_on_rise(input logic [1:0] mode);
      return mode[1] == mode[0];
   endfunction

endpackage

// File: rtl/spi_slave_sync_if.sv
// spi_slave_sync_if: parallel word side of the SPI slave.
//   tx_data/tx_valid/tx_ready : words to be shifted out on miso
//   rx_data/rx_valid/rx_ready : words received from mosi
//   tx_underrun/rx_overrun    : one-clk error pulses
//
// Handshake: a word moves on a rising clk edge where valid and ready are
// both high. The producer holds valid and data stable until that edge;
// ready may change freely and does not depend on valid.
interface spi_slave_sync_if #(
   parameter int BITS = 8
) ();

   logic [BITS-1:0] tx_data;
   logic            tx_valid;
   logic            tx_ready;
   logic [BITS-1:0] rx_data;
   logic            rx_valid;
   logic            rx_ready;
   logic            tx_underrun;
   logic            rx_overrun;

   // Seen from the SPI slave block.
   modport slave (
      input  tx_data, tx_valid, rx_ready,
      output tx_ready, rx_data, rx_valid, tx_underrun, rx_overrun
   );

   // Seen from the user logic that feeds TX and drains RX.
   modport master (
      output tx_data, tx_valid, rx_ready,
      input  tx_ready, rx_data, rx_valid, tx_underrun, rx_overrun
   );

endinterface

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: flop chain bringing one asynchronous pin into the clk domain.
//   clk, rst_n : system clock, asynchronous active-low reset
//   din        : asynchronous input pin
//   dout       : synchronised copy, SYNC_STAGES clk later
module spi_pin_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   logic [SYNC_STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= {SYNC_STAGES{RESET_VAL}};
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], din};
      end
   end

   assign dout = chain[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: SPI slave running entirely on the system clock.
// sclk, ss_n and mosi are oversampled; all four SPI modes are supported and
// the mode is captured at the start of each ss_n frame.
//   clk, rst_n      : system clock (>= 4x sclk), async active-low reset
//   sclk, ss_n, mosi: asynchronous SPI pins
//   mode            : {CPOL, CPHA}, sampled at frame start
//   miso, miso_oe   : registered serial output and pad enable
//   busy            : frame active
//   fsm_state       : current frame FSM state (observation only)
//   bus             : TX/RX word handshakes and error pulses
module spi_slave_sync
   import spi_pkg::*;
#(
   parameter int              BITS        = 8,
   parameter int              LSB_FIRST   = 0,
   parameter int              SYNC_STAGES = 2,
   parameter logic [BITS-1:0] TX_FILL     = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sclk,
   input  logic              ss_n,
   input  logic              mosi,
   input  logic [1:0]        mode,
   output logic              miso,
   output logic              miso_oe,
   output logic              busy,
   output spi_state_t        fsm_state,
   spi_slave_sync_if.slave   bus
);

   localparam int             CW   = $clog2(BITS);
   localparam logic [CW-1:0]  LAST = CW'(BITS - 1);

   // ---------------------------------------------------------------
   // Pin synchronisers and edge detection
   // ---------------------------------------------------------------
   logic sclk_s, ss_s, mosi_s;
   logic sclk_d, ss_d;

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst_n(rst_n), .din(sclk), .dout(sclk_s)
   );

   // ss_n resets to the asserted level so a select already held low
   // across reset release does not look like a new frame.
   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_ss (
      .clk(clk), .rst_n(rst_n), .din(ss_n), .dout(ss_s)
   );

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst_n(rst_n), .din(mosi), .dout(mosi_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_d <= 1'b0;
         ss_d   <= 1'b0;
      end else begin
         sclk_d <= sclk_s;
         ss_d   <= ss_s;
      end
   end

   logic sclk_rise, sclk_fall, ss_fall;

   // Edges are decoded from the last sync stage, so mosi_s (same depth)
   // is exactly the value present at the pin edge.
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign ss_fall   = ~ss_s & ss_d;

   // ---------------------------------------------------------------
   // Frame FSM
   // ---------------------------------------------------------------
   spi_state_t state_q, state_d;
   logic       frame_start, frame_end;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      case (state_q)
         IDLE: begin
            if (ss_fall) begin
               state_d     = ACTIVE;
               frame_start = 1'b1;
            end
         end
         ACTIVE: begin
            if (ss_s) begin
               state_d   = IDLE;
               frame_end = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Edge qualification
   // ---------------------------------------------------------------
   logic [1:0]      mode_q;
   logic [CW-1:0]   bit_cnt;
   logic            in_frame, sample_ev, shift_ev, word_done, load_ev, shift_only;

   assign in_frame  = (state_q == ACTIVE) && !ss_s;
   assign sample_ev = in_frame && (sample_on_rise(mode_q) ? sclk_rise : sclk_fall);
   assign shift_ev  = in_frame && (sample_on_rise(mode_q) ? sclk_fall : sclk_rise);
   assign word_done = sample_ev && (bit_cnt == LAST);

   // A shift edge seen with bit_cnt == 0 is the first leading edge of a
   // word for CPHA=1, and the edge right after a word's last sample for
   // CPHA=0. CPHA=0 additionally preloads at the start of the frame.
   assign load_ev    = (frame_start && !mode[0]) || (shift_ev && (bit_cnt == '0));
   assign shift_only = shift_ev && (bit_cnt != '0);

   // ---------------------------------------------------------------
   // Shift paths
   // ---------------------------------------------------------------
   logic [BITS-1:0] rx_shift, tx_shift;
   logic [BITS-1:0] rx_word, tx_shifted;
   logic            miso_bit;
   logic [BITS-1:0] tx_buf;
   logic            tx_full;
   logic            tx_wr;

   always_comb begin
      rx_word    = '0;
      tx_shifted = '0;
      miso_bit   = 1'b0;
      if (LSB_FIRST != 0) begin
         rx_word    = {mosi_s, rx_shift[BITS-1:1]};
         tx_shifted = {1'b0, tx_shift[BITS-1:1]};
         miso_bit   = tx_shift[0];
      end else begin
         rx_word    = {rx_shift[BITS-2:0], mosi_s};
         tx_shifted = {tx_shift[BITS-2:0], 1'b0};
         miso_bit   = tx_shift[BITS-1];
      end
   end

   assign tx_wr        = bus.tx_valid && !tx_full;
   assign bus.tx_ready = !tx_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q   <= 2'b00;
         bit_cnt  <= '0;
         rx_shift <= '0;
         tx_shift <= '0;
         miso     <= 1'b0;
      end else begin
         if (frame_start) begin
            mode_q <= mode;
         end

         if (frame_start || frame_end) begin
            bit_cnt <= '0;
         end else if (sample_ev) begin
            bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
         end

         // A partial word left over from an aborted frame is dropped here.
         if (frame_start) begin
            rx_shift <= '0;
         end else if (sample_ev) begin
            rx_shift <= rx_word;
         end

         if (frame_end) begin
            tx_shift <= '0;
         end else if (load_ev) begin
            tx_shift <= tx_full ? tx_buf : TX_FILL;
         end else if (shift_only) begin
            tx_shift <= tx_shifted;
         end

         miso <= (state_q == ACTIVE) ? miso_bit : 1'b0;
      end
   end

   // ---------------------------------------------------------------
   // TX holding buffer
   // ---------------------------------------------------------------
   // A write can only happen while the buffer is empty, so a load in the
   // same cycle sees empty (underrun) and the new word lands after it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_buf          <= '0;
         tx_full         <= 1'b0;
         bus.tx_underrun <= 1'b0;
      end else begin
         bus.tx_underrun <= load_ev && !tx_full;
         if (tx_wr) begin
            tx_buf  <= bus.tx_data;
            tx_full <= 1'b1;
         end else if (load_ev) begin
            tx_full <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------
   // RX output register
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rx_data    <= '0;
         bus.rx_valid   <= 1'b0;
         bus.rx_overrun <= 1'b0;
      end else begin
         bus.rx_overrun <= word_done && bus.rx_valid && !bus.rx_ready;
         if (word_done && (!bus.rx_valid || bus.rx_ready)) begin
            bus.rx_data  <= rx_word;
            bus.rx_valid <= 1'b1;
         end else if (bus.rx_valid && bus.rx_ready) begin
            bus.rx_valid <= 1'b0;
         end
      end
   end

   assign busy      = (state_q == ACTIVE);
   assign miso_oe   = (state_q == ACTIVE);
   assign fsm_state = state_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
module tb_spi_slave_sync;
   import spi_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // ---------------- pins ----------------
   logic       sclk, mosi, ss_a, ss_b;
   logic [1:0] mode;
   logic       miso_a, miso_b, oe_a, oe_b, busy_a, busy_b;
   spi_state_t st_a, st_b;

   spi_slave_sync_if #(.BITS(8)) bus_a ();
   spi_slave_sync_if #(.BITS(8)) bus_b ();

   // MSB-first instance with a recognisable fill word.
   spi_slave_sync #(.BITS(8), .LSB_FIRST(0), .SYNC_STAGES(2), .TX_FILL(8'hC3)) dut_a (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .ss_n(ss_a), .mosi(mosi), .mode(mode),
      .miso(miso_a), .miso_oe(oe_a), .busy(busy_a), .fsm_state(st_a), .bus(bus_a.slave)
   );

   // LSB-first instance.
   spi_slave_sync #(.BITS(8), .LSB_FIRST(1), .SYNC_STAGES(2), .TX_FILL(8'h00)) dut_b (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .ss_n(ss_b), .mosi(mosi), .mode(mode),
      .miso(miso_b), .miso_oe(oe_b), .busy(busy_b), .fsm_state(st_b), .bus(bus_b.slave)
   );

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_fail = 0;
   logic [7:0] exp_q[$];
   logic [7:0] got_a[$];
   logic [7:0] got_b[$];
   int und_a = 0, ovr_a = 0, und_b = 0, ovr_b = 0;

   always @(negedge clk) begin
      if (bus_a.rx_valid && bus_a.rx_ready) got_a.push_back(bus_a.rx_data);
      if (bus_b.rx_valid && bus_b.rx_ready) got_b.push_back(bus_b.rx_data);
      if (bus_a.tx_underrun) und_a++;
      if (bus_a.rx_overrun)  ovr_a++;
      if (bus_b.tx_underrun) und_b++;
      if (bus_b.rx_overrun)  ovr_b++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_rx(input int sel, input string tag);
      logic [7:0] g, e;
      chk({tag, "_count"}, (sel == 0) ? got_a.size() : got_b.size(), exp_q.size());
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = 8'hxx;
         if (sel == 0 && got_a.size() > 0) g = got_a.pop_front();
         if (sel == 1 && got_b.size() > 0) g = got_b.pop_front();
         chk({tag, "_data"}, g, e);
      end
      got_a.delete();
      got_b.delete();
   endtask

   // ---------------- driver tasks ----------------
   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_tx(input int sel, input logic [7:0] d);
      int waited = 0;
      while (((sel == 0) ? bus_a.tx_ready : bus_b.tx_ready) !== 1'b1 && waited < 400) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 400) begin
         n_cmp++;
         n_fail++;
         $error("FAIL tx_push_timeout: tx_ready observed 0 expected 1");
      end else begin
         if (sel == 0) begin bus_a.tx_data = d; bus_a.tx_valid = 1'b1; end
         else          begin bus_b.tx_data = d; bus_b.tx_valid = 1'b1; end
         @(negedge clk);
         bus_a.tx_valid = 1'b0;
         bus_b.tx_valid = 1'b0;
      end
   endtask

   task automatic open_frame(input int sel, input logic [1:0] m);
      mode = m;
      sclk = m[1];
      wait_neg(4);
      if (sel == 0) ss_a = 1'b0; else ss_b = 1'b0;
      wait_neg(6);
   endtask

   task automatic close_frame(input int sel);
      wait_neg(4);
      if (sel == 0) ss_a = 1'b1; else ss_b = 1'b1;
      wait_neg(8);
   endtask

   // Master side: sclk half period = 4 clk; bit order follows the instance.
   task automatic xfer(input int sel, input int nbits, input logic [7:0] mo,
                       output logic [7:0] mi);
      logic cpol, cpha;
      int   idx;
      cpol = mode[1];
      cpha = mode[0];
      mi = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         idx = (sel == 1) ? i : 7 - i;
         if (!cpha) begin
            mosi = mo[idx];
            wait_neg(4);
            sclk = ~cpol;
            mi[idx] = (sel == 1) ? miso_b : miso_a;
            wait_neg(4);
            sclk = cpol;
         end else begin
            sclk = ~cpol;
            mosi = mo[idx];
            wait_neg(4);
            sclk = cpol;
            mi[idx] = (sel == 1) ? miso_b : miso_a;
            wait_neg(4);
         end
      end
   endtask

   // ---------------- directed sequence ----------------
   logic [7:0] mi, mi1, mi2, mi3;
   int u0, o0;
   logic [1:0] mlist [3];

   initial begin
      rst_n = 1'b0;
      sclk = 1'b0; mosi = 1'b0; ss_a = 1'b1; ss_b = 1'b1; mode = SPI_MODE0;
      bus_a.tx_valid = 1'b0; bus_a.tx_data = 8'h00; bus_a.rx_ready = 1'b1;
      bus_b.tx_valid = 1'b0; bus_b.tx_data = 8'h00; bus_b.rx_ready = 1'b1;
      wait_neg(3);

      // reset values
      chk("rst_miso", miso_a, 1'b0);
      chk("rst_oe", oe_a, 1'b0);
      chk("rst_busy", busy_a, 1'b0);
      chk("rst_tx_ready", bus_a.tx_ready, 1'b1);
      chk("rst_rx_valid", bus_a.rx_valid, 1'b0);
      chk("rst_rx_data", bus_a.rx_data, 8'h00);
      chk("rst_underrun", bus_a.tx_underrun, 1'b0);
      chk("rst_overrun", bus_a.rx_overrun, 1'b0);
      chk("rst_state", 32'(st_a), 32'(IDLE));
      rst_n = 1'b1;
      wait_neg(4);

      // mode 0, MSB first: slave sends A5, master sends 3C
      push_tx(0, 8'hA5);
      chk("m0_tx_full", bus_a.tx_ready, 1'b0);
      u0 = und_a;
      open_frame(0, SPI_MODE0);
      chk("m0_busy", busy_a, 1'b1);
      chk("m0_oe", oe_a, 1'b1);
      chk("m0_preload", bus_a.tx_ready, 1'b1);
      exp_q.push_back(8'h3C);
      xfer(0, 8, 8'h3C, mi);
      close_frame(0);
      chk("m0_miso_word", mi, 8'hA5);
      check_rx(0, "m0_rx");
      // the edge after the last sample reloads from an empty buffer
      chk("m0_end_underrun", und_a - u0, 1);
      chk("m0_idle_busy", busy_a, 1'b0);
      chk("m0_idle_oe", oe_a, 1'b0);
      chk("m0_idle_miso", miso_a, 1'b0);

      // modes 1/2/3, LSB first: slave sends 01, master sends 80
      mlist[0] = SPI_MODE1; mlist[1] = SPI_MODE2; mlist[2] = SPI_MODE3;
      for (int k = 0; k < 3; k++) begin
         push_tx(1, 8'h01);
         open_frame(1, mlist[k]);
         exp_q.push_back(8'h80);
         xfer(1, 8, 8'h80, mi);
         close_frame(1);
         chk($sformatf("lsb_m%0d_first_bit", mlist[k]), mi[0], 1'b1);
         chk($sformatf("lsb_m%0d_miso_word", mlist[k]), mi, 8'h01);
         check_rx(1, $sformatf("lsb_m%0d_rx", mlist[k]));
      end

      // three back-to-back words, mode 1, TX refilled during the frame
      push_tx(0, 8'h11);
      u0 = und_a;
      open_frame(0, SPI_MODE1);
      exp_q.push_back(8'h5A); exp_q.push_back(8'h6B); exp_q.push_back(8'h7C);
      fork
         begin
            xfer(0, 8, 8'h5A, mi1);
            xfer(0, 8, 8'h6B, mi2);
            xfer(0, 8, 8'h7C, mi3);
         end
         begin
            push_tx(0, 8'h22);
            push_tx(0, 8'h33);
         end
      join
      close_frame(0);
      chk("b2b_w1", mi1, 8'h11);
      chk("b2b_w2", mi2, 8'h22);
      chk("b2b_w3", mi3, 8'h33);
      chk("b2b_underrun", und_a - u0, 0);
      check_rx(0, "b2b_rx");

      // empty TX and stalled RX, mode 1: two loads both underrun
      bus_a.rx_ready = 1'b0;
      u0 = und_a;
      o0 = ovr_a;
      open_frame(0, SPI_MODE1);
      xfer(0, 8, 8'h96, mi1);
      xfer(0, 8, 8'h69, mi2);
      close_frame(0);
      chk("ur_w1_fill", mi1, 8'hC3);
      chk("ur_w2_fill", mi2, 8'hC3);
      chk("ur_underrun", und_a - u0, 2);
      chk("ur_overrun", ovr_a - o0, 1);
      chk("ur_rx_valid", bus_a.rx_valid, 1'b1);
      chk("ur_rx_kept", bus_a.rx_data, 8'h96);
      bus_a.rx_ready = 1'b1;
      wait_neg(2);
      chk("ur_rx_drain", bus_a.rx_valid, 1'b0);
      exp_q.push_back(8'h96);
      check_rx(0, "ur_rx");

      // aborted frame after 5 bits, then a clean F0
      open_frame(0, SPI_MODE0);
      xfer(0, 5, 8'hFF, mi);
      close_frame(0);
      check_rx(0, "abort_rx");
      open_frame(0, SPI_MODE0);
      exp_q.push_back(8'hF0);
      xfer(0, 8, 8'hF0, mi);
      close_frame(0);
      check_rx(0, "after_abort_rx");
      chk("after_abort_data", bus_a.rx_data, 8'hF0);

      // reset in the middle of a word
      push_tx(0, 8'h3C);
      open_frame(0, SPI_MODE0);
      push_tx(0, 8'h77);
      chk("mid_tx_full", bus_a.tx_ready, 1'b0);
      xfer(0, 4, 8'hAA, mi);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_miso", miso_a, 1'b0);
      chk("mid_rst_oe", oe_a, 1'b0);
      chk("mid_rst_busy", busy_a, 1'b0);
      chk("mid_rst_tx_ready", bus_a.tx_ready, 1'b1);
      chk("mid_rst_rx_valid", bus_a.rx_valid, 1'b0);
      chk("mid_rst_rx_data", bus_a.rx_data, 8'h00);
      chk("mid_rst_state", 32'(st_a), 32'(IDLE));
      wait_neg(2);
      rst_n = 1'b1;
      wait_neg(6);
      chk("post_rst_no_frame", busy_a, 1'b0);
      ss_a = 1'b1;
      wait_neg(8);
      push_tx(0, 8'hE7);
      open_frame(0, SPI_MODE0);
      exp_q.push_back(8'h42);
      xfer(0, 8, 8'h42, mi);
      close_frame(0);
      chk("post_rst_miso_word", mi, 8'hE7);
      check_rx(0, "post_rst_rx");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
